sync_ram_sdp: RTL and testbench
===============================

// Module: sync_ram_sdp
// PURPOSE
//  Parametrised simple-dual-port synchronous RAM: one write port (A), one read port (B), one clock.
//  Next generation of the team's single-port RAM: byte enables, registered read with valid strobe,
//  selectable read-during-write mode, out-of-range detection and a hardware clear sequence after reset.
//  Used as working storage for datapath/register-file experiments in the practical designs.
// PARAMETERS
//  DATA_WIDTH  32             word width in bits; must be a multiple of 8
//  DEPTH       256            number of words; need not be a power of two
//  ADDR_WIDTH  $clog2(DEPTH)  address width in bits
//  RDW_MODE    0              same-address read during write: 0 = old data, 1 = new data (forwarded)
//  CLEAR_VAL   0              word value written to every location by the clear sequence
// PORTS
//  clk         in   1             clock; all state changes on the rising edge
//  rst_n       in   1             asynchronous, active-low reset
//  a_we        in   1             write request
//  a_addr      in   ADDR_WIDTH    write address
//  a_be        in   DATA_WIDTH/8  byte enables; bit i gates byte [8i+7:8i]
//  a_wdata     in   DATA_WIDTH    write data
//  b_re        in   1             read request
//  b_addr      in   ADDR_WIDTH    read address
//  b_rdata     out  DATA_WIDTH    read data, registered
//  b_rvalid    out  1             b_rdata valid; one-cycle pulse per accepted read
//  init_busy   out  1             clear sequence running; all requests ignored
//  oor_err     out  1             one-cycle pulse: a request addressed >= DEPTH
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): b_rdata=0, b_rvalid=0, oor_err=0, init_busy=1, clear counter=0, FSM=CLEAR.
//  FSM: CLEAR -> READY when counter == DEPTH-1; READY -> CLEAR only on reset.
//  CLEAR: writes CLEAR_VAL to mem[counter] each cycle, counter+1; takes exactly DEPTH cycles after rst_n rises.
//   a_we/b_re ignored; no b_rvalid, no oor_err. init_busy drops in the cycle after the last clear write.
//  READY write: if a_we and a_addr<DEPTH, byte i of mem[a_addr] <= a_wdata byte i where a_be[i]=1.
//   a_be=0 is a legal no-op.
//  READY read: if b_re, then next cycle b_rvalid=1 and b_rdata=mem[b_addr]; latency 1 cycle.
//   b_rdata holds its last value when b_rvalid=0.
//  Same-cycle a_we and b_re to the same in-range address:
//   RDW_MODE=0 -> b_rdata = pre-write word; RDW_MODE=1 -> enabled bytes from a_wdata, others from mem.
//  Out of range (addr >= DEPTH, only when DEPTH < 2**ADDR_WIDTH): the write is dropped;
//   the read returns b_rdata=0 with b_rvalid=1. oor_err pulses next cycle if either port is out of range.
//  Reset mid-clear or mid-read: the in-flight read is discarded (b_rvalid=0) and the clear restarts from 0.
//  Memory contents are not reset asynchronously; only the clear sequence initialises them.
// CONFIGURATION
//  SYNC_RAM_PARITY_EN defined: one even-parity bit stored per byte (written with that byte, and by clear).
//   The read checks parity and adds output par_err (1 bit, reset 0), which pulses alongside b_rvalid
//   when any byte mismatches. Data is returned unmodified. Out-of-range reads never flag.
//  SYNC_RAM_PARITY_EN undefined: no parity storage and no par_err port.
// STRUCTURE
//  Package sync_ram_pkg holds:
//   - RDW_OLD=0, RDW_NEW=1 constants;
//   - the FSM enum clr_state_t {CLEAR, READY};
//   - a function that builds the byte-merge mask from the byte enables.
//  Sub-module sync_ram_clear_ctrl holds the clear FSM and address counter, and outputs init_busy,
//   clear_we and clear_addr. The top muxes the clear write onto the write port.
//  The storage array is inferred in the top, one always block per port.
// TESTING (DATA_WIDTH=32, DEPTH=200, ADDR_WIDTH=8)
//  1. Release rst_n; read addr 0..199 after init_busy falls
//     -> init_busy high exactly 200 cycles, every read 0x00000000 with b_rvalid.
//  2. Write 0xDEADBEEF to addr 5 with be=4'b1111, then 0x000000AA with be=4'b0001; read 5
//     -> 0xDEADBEAA, 1 cycle later.
//  3. Read 5 in the same cycle as a write of 0x12345678 to 5
//     -> RDW_MODE=0: 0xDEADBEAA; RDW_MODE=1: 0x12345678.
//  4. Write addr 210, then read addr 210
//     -> no write, b_rdata=0, b_rvalid=1, oor_err pulses once per request; addr 199 unchanged.
//  5. Assert rst_n low at clear cycle 100 and during a pending read
//     -> b_rvalid=0 immediately; full 200-cycle clear reruns.
//  6. With SYNC_RAM_PARITY_EN: force one stored parity bit of addr 7, read 7
//     -> par_err=1 with b_rvalid; clean addresses give par_err=0.

Source files
------------

// File: rtl/sync_ram_pkg.sv
// Shared constants, clear-FSM state type and byte-mask helper for the sync_ram_sdp RAM.
package sync_ram_pkg;

    localparam int RDW_OLD   = 0;
    localparam int RDW_NEW   = 1;
    localparam int MAX_BYTES = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    // Expands each byte enable into eight mask bits; callers cast down to their word width.
    function automatic logic [8*MAX_BYTES-1:0] be_mask(input logic [MAX_BYTES-1:0] be);
        logic [8*MAX_BYTES-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sync_ram_clear_ctrl.sv
// Post-reset clear sequencer: walks every RAM address once, then hands the write port back.
//   state | meaning
//   CLEAR | writing the clear value to clear_addr, one word per cycle
//   READY | clear done; RAM serves user requests until the next reset
module sync_ram_clear_ctrl
    import sync_ram_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_busy,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    clr_state_t            state;
    clr_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR && cnt != LAST) begin
                cnt <= cnt + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt == LAST) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        init_busy  = (state == CLEAR);
        clear_we   = (state == CLEAR);
        clear_addr = cnt;
    end

endmodule

// File: rtl/sync_ram_sdp.sv
// Simple-dual-port synchronous RAM with byte enables, registered read, RDW mode and clear-on-reset.
// Optional per-byte even parity with par_err output when SYNC_RAM_PARITY_EN is defined.
module sync_ram_sdp
    import sync_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter int                    ADDR_WIDTH = $clog2(DEPTH),
    parameter int                    RDW_MODE   = RDW_OLD,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    input  logic                    b_re,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid,
    output logic                    init_busy,
`ifdef SYNC_RAM_PARITY_EN
    output logic                    par_err,
`endif
    output logic                    oor_err
);

    localparam int                  NB      = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef SYNC_RAM_PARITY_EN
    logic [NB-1:0]         par_mem [DEPTH];
    logic                  par_bad;
`endif

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  ready;
    logic                  a_in;
    logic                  b_in;
    logic                  rd_fire;
    logic [ADDR_WIDTH-1:0] b_idx;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NB-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] fwd_mask;
    logic [DATA_WIDTH-1:0] rd_word;

    sync_ram_clear_ctrl #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_busy  (init_busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    assign ready    = ~init_busy;
    assign a_in     = {1'b0, a_addr} < DEPTH_W;
    assign b_in     = {1'b0, b_addr} < DEPTH_W;
    assign rd_fire  = ready & b_re;
    assign b_idx    = b_in ? b_addr : '0;
    assign fwd_mask = DATA_WIDTH'(be_mask(MAX_BYTES'(a_be)));

    // The clear sequence owns the write port while busy.
    assign wr_en   = clear_we | (ready & a_we & a_in);
    assign wr_addr = clear_we ? clear_addr : a_addr;
    assign wr_be   = clear_we ? {NB{1'b1}} : a_be;
    assign wr_data = clear_we ? CLEAR_VAL : a_wdata;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
`ifdef SYNC_RAM_PARITY_EN
                    par_mem[wr_addr][i] <= ^wr_data[8*i +: 8];
`endif
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (b_in) begin
            rd_word = mem[b_idx];
            if (RDW_MODE == RDW_NEW && a_we && a_in && a_addr == b_addr) begin
                rd_word = (mem[b_idx] & ~fwd_mask) | (a_wdata & fwd_mask);
            end
        end
    end

`ifdef SYNC_RAM_PARITY_EN
    // Checked against the stored word, so a forwarded read still reports the array's health.
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (par_mem[b_idx][i] != ^mem[b_idx][8*i +: 8]) par_bad = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rdata  <= '0;
            b_rvalid <= 1'b0;
            oor_err  <= 1'b0;
`ifdef SYNC_RAM_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
            b_rvalid <= rd_fire;
            oor_err  <= ready & ((a_we & ~a_in) | (b_re & ~b_in));
            if (rd_fire) begin
                b_rdata <= rd_word;
            end
`ifdef SYNC_RAM_PARITY_EN
            par_err  <= rd_fire & b_in & par_bad;
`endif
        end
    end

endmodule

// File: tb/tb_sync_ram_sdp.sv
// Directed self-checking bench for sync_ram_sdp (DATA_WIDTH=32, DEPTH=200, ADDR_WIDTH=8).
module tb_sync_ram_sdp;

    localparam int DW  = 32;
    localparam int DEP = 200;
    localparam int AW  = 8;
    localparam int RDW = 0;

    logic          clk;
    logic          rst_n;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [3:0]    a_be;
    logic [DW-1:0] a_wdata;
    logic          b_re;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_rdata;
    logic          b_rvalid;
    logic          init_busy;
    logic          oor_err;
`ifdef SYNC_RAM_PARITY_EN
    logic          par_err;
`endif

    int checks = 0;
    int errors = 0;

    sync_ram_sdp #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .ADDR_WIDTH (AW),
        .RDW_MODE   (RDW),
        .CLEAR_VAL  (32'h0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_be      (a_be),
        .a_wdata   (a_wdata),
        .b_re      (b_re),
        .b_addr    (b_addr),
        .b_rdata   (b_rdata),
        .b_rvalid  (b_rvalid),
        .init_busy (init_busy),
`ifdef SYNC_RAM_PARITY_EN
        .par_err   (par_err),
`endif
        .oor_err   (oor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_we = 1'b0; a_addr = '0; a_be = '0; a_wdata = '0;
        b_re = 1'b0; b_addr = '0;
    endtask

    // Releases reset at a falling edge and returns how many rising edges init_busy stayed high.
    task automatic run_clear(output int n, output int side_errs);
        n = 0;
        side_errs = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            n++;
            if (b_rvalid !== 1'b0 || oor_err !== 1'b0) side_errs++;
            if (init_busy !== 1'b1) break;
        end
        idle_inputs();
    endtask

    task automatic read_word(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic valid);
        b_re = 1'b1;
        b_addr = addr;
        tick();
        data = b_rdata;
        valid = b_rvalid;
        b_re = 1'b0;
    endtask

    task automatic write_word(input logic [AW-1:0] addr, input logic [3:0] be, input logic [DW-1:0] data);
        a_we = 1'b1; a_addr = addr; a_be = be; a_wdata = data;
        tick();
        a_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        b_re = 1'b1;
        a_we = 1'b1;
        a_addr = 8'd3;
        a_be = 4'hF;
        a_wdata = 32'hFFFF_FFFF;
        repeat (3) tick();
        checks++;
        if (b_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata actual=%h required=%h", b_rdata, 32'h0); end
        checks++;
        if (b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid actual=%b required=0", b_rvalid); end
        checks++;
        if (oor_err !== 1'b0) begin errors++; $display("FAIL reset_oor actual=%b required=0", oor_err); end
        checks++;
        if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy actual=%b required=1", init_busy); end
    endtask

    task automatic test_clear();
        int n;
        int side;
        int bad;
        logic [DW-1:0] d;
        logic v;
        // Requests during clear must be ignored, including an out-of-range read.
        a_we = 1'b1; a_addr = 8'd3; a_be = 4'hF; a_wdata = 32'hFFFF_FFFF;
        b_re = 1'b1; b_addr = 8'd210;
        run_clear(n, side);
        checks++;
        if (n !== DEP) begin errors++; $display("FAIL clear_length actual=%0d required=%0d", n, DEP); end
        checks++;
        if (side !== 0) begin errors++; $display("FAIL clear_quiet actual=%0d required=0", side); end
        bad = 0;
        for (int i = 0; i < DEP; i++) begin
            read_word(AW'(i), d, v);
            if (d !== 32'h0 || v !== 1'b1) begin
                bad++;
                if (bad < 4) $display("FAIL clear_read addr=%0d actual=%h/%b required=00000000/1", i, d, v);
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL clear_read_total actual=%0d required=0", bad); end
    endtask

    task automatic test_write_be();
        logic [DW-1:0] d;
        logic v;
        write_word(8'd5, 4'b1111, 32'hDEAD_BEEF);
        write_word(8'd5, 4'b0001, 32'h0000_00AA);
        read_word(8'd5, d, v);
        checks++;
        if (d !== 32'hDEAD_BEAA || v !== 1'b1) begin errors++; $display("FAIL be_merge actual=%h/%b required=deadbeaa/1", d, v); end
        tick();
        checks++;
        if (b_rvalid !== 1'b0 || b_rdata !== 32'hDEAD_BEAA) begin errors++; $display("FAIL rdata_hold actual=%h/%b required=deadbeaa/0", b_rdata, b_rvalid); end
        write_word(8'd5, 4'b0000, 32'h0000_0000);
        read_word(8'd5, d, v);
        checks++;
        if (d !== 32'hDEAD_BEAA) begin errors++; $display("FAIL be_zero_noop actual=%h required=deadbeaa", d); end
        write_word(8'd6, 4'b0110, 32'h1122_3344);
        read_word(8'd6, d, v);
        checks++;
        if (d !== 32'h0022_3300) begin errors++; $display("FAIL be_middle actual=%h required=00223300", d); end
    endtask

    task automatic test_rdw();
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
        exp1 = (RDW == 1) ? 32'h1234_5678 : 32'hDEAD_BEAA;
        exp2 = (RDW == 1) ? 32'h0022_33DD : 32'h0022_3300;
        a_we = 1'b1; a_addr = 8'd5; a_be = 4'hF; a_wdata = 32'h1234_5678;
        b_re = 1'b1; b_addr = 8'd5;
        tick();
        idle_inputs();
        checks++;
        if (b_rdata !== exp1 || b_rvalid !== 1'b1) begin errors++; $display("FAIL rdw_full actual=%h/%b required=%h/1", b_rdata, b_rvalid, exp1); end
        a_we = 1'b1; a_addr = 8'd6; a_be = 4'b0001; a_wdata = 32'hAABB_CCDD;
        b_re = 1'b1; b_addr = 8'd6;
        tick();
        idle_inputs();
        checks++;
        if (b_rdata !== exp2) begin errors++; $display("FAIL rdw_partial actual=%h required=%h", b_rdata, exp2); end
        b_re = 1'b1; b_addr = 8'd5;
        tick();
        b_re = 1'b0;
        checks++;
        if (b_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rdw_after actual=%h required=12345678", b_rdata); end
    endtask

    task automatic test_oor();
        logic [DW-1:0] d;
        logic v;
        write_word(8'd210, 4'hF, 32'hFFFF_FFFF);
        checks++;
        if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_write_pulse actual=%b required=1", oor_err); end
        tick();
        checks++;
        if (oor_err !== 1'b0) begin errors++; $display("FAIL oor_write_once actual=%b required=0", oor_err); end
        read_word(8'd210, d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1 || oor_err !== 1'b1) begin
            errors++; $display("FAIL oor_read actual=%h/%b/%b required=00000000/1/1", d, v, oor_err);
        end
        tick();
        checks++;
        if (oor_err !== 1'b0) begin errors++; $display("FAIL oor_read_once actual=%b required=0", oor_err); end
        read_word(8'd199, d, v);
        checks++;
        if (d !== 32'h0 || oor_err !== 1'b0) begin errors++; $display("FAIL oor_last_unchanged actual=%h/%b required=00000000/0", d, oor_err); end
        read_word(8'd10, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL oor_no_alias actual=%h required=00000000", d); end
        write_word(8'd199, 4'hF, 32'hCAFE_F00D);
        checks++;
        if (oor_err !== 1'b0) begin errors++; $display("FAIL last_addr_no_oor actual=%b required=0", oor_err); end
        read_word(8'd199, d, v);
        checks++;
        if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL last_addr_write actual=%h required=cafef00d", d); end
    endtask

    task automatic test_reset_mid();
        int n;
        int side;
        logic [DW-1:0] d;
        logic v;
        b_re = 1'b1; b_addr = 8'd5;
        tick();
        b_re = 1'b0;
        checks++;
        if (b_rvalid !== 1'b1) begin errors++; $display("FAIL pending_read actual=%b required=1", b_rvalid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (b_rvalid !== 1'b0 || init_busy !== 1'b1 || b_rdata !== 32'h0) begin
            errors++; $display("FAIL async_reset actual=%b/%b/%h required=0/1/00000000", b_rvalid, init_busy, b_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) tick();
        checks++;
        if (init_busy !== 1'b1) begin errors++; $display("FAIL busy_at_100 actual=%b required=1", init_busy); end
        rst_n = 1'b0;
        #1;
        run_clear(n, side);
        checks++;
        if (n !== DEP) begin errors++; $display("FAIL reclear_length actual=%0d required=%0d", n, DEP); end
        read_word(8'd5, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reclear_addr5 actual=%h required=00000000", d); end
        read_word(8'd199, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reclear_addr199 actual=%h required=00000000", d); end
    endtask

`ifdef SYNC_RAM_PARITY_EN
    task automatic test_parity();
        logic [DW-1:0] d;
        logic v;
        write_word(8'd7, 4'hF, 32'h0102_0304);
        dut.par_mem[7][0] = ~dut.par_mem[7][0];
        b_re = 1'b1; b_addr = 8'd7;
        tick();
        b_re = 1'b0;
        checks++;
        if (par_err !== 1'b1 || b_rvalid !== 1'b1 || b_rdata !== 32'h0102_0304) begin
            errors++; $display("FAIL parity_flag actual=%b/%b/%h required=1/1/01020304", par_err, b_rvalid, b_rdata);
        end
        read_word(8'd5, d, v);
        checks++;
        if (par_err !== 1'b0) begin errors++; $display("FAIL parity_clean actual=%b required=0", par_err); end
        read_word(8'd220, d, v);
        checks++;
        if (par_err !== 1'b0) begin errors++; $display("FAIL parity_oor actual=%b required=0", par_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_clear();
        test_write_be();
        test_rdw();
        test_oor();
        test_reset_mid();
`ifdef SYNC_RAM_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
